// File: rtl/uart_cmd_responder.sv
// Byte-command responder: 'W' addr data writes a register, 'R' addr reads one back.
// Replies are pushed to the TX FIFO; a stalled command is dropped after TIMEOUT_CYCLES idle cycles.
//
// state    | meaning
// IDLE     | wait for an opcode byte
// GET_ADDR | wait for the address byte
// GET_DATA | wait for the data byte of a write
// EXEC     | perform the write or read, choose the reply
// SEND     | push the reply once the TX FIFO has room
`timescale 1ns/1ps
module uart_cmd_responder #(
    parameter int TIMEOUT_CYCLES = 270000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx_fifo_empty,
    input  logic [7:0]   rx_fifo_data_out,
    output logic         rx_fifo_read_en,
    input  logic         tx_fifo_full,
    output logic [7:0]   tx_fifo_data_in,
    output logic         tx_fifo_write_en,
    output logic [127:0] regs_flat,
    output logic         write_strobe,
    output logic [3:0]   write_addr,
    output logic         Debug_cmd
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_TC = TW'(TIMEOUT_CYCLES);

    localparam logic [7:0] OP_WR    = 8'h57;
    localparam logic [7:0] OP_RD    = 8'h52;
    localparam logic [7:0] RPL_BAD  = 8'h3F;
    localparam logic [7:0] RPL_ERR  = 8'h45;
    localparam logic [7:0] RPL_OK   = 8'h4B;

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND} state_t;

    state_t           state, state_nxt;
    logic             is_wr, is_wr_nxt;
    logic [7:0]       addr, addr_nxt;
    logic [7:0]       data, data_nxt;
    logic [7:0]       reply, reply_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [15:0][7:0] regs;
    logic             pop, can_pop, reg_we;
    logic             tx_we_nxt, debug_nxt;
    logic [7:0]       tx_data_nxt;

    // The head byte is captured when the pop strobe is scheduled; the strobe itself
    // lands one cycle later, so a byte is never consumed twice in a row.
    assign can_pop   = !rx_fifo_empty && !rx_fifo_read_en;
    assign regs_flat = regs;

    always_comb begin
        state_nxt   = state;
        is_wr_nxt   = is_wr;
        addr_nxt    = addr;
        data_nxt    = data;
        reply_nxt   = reply;
        timer_nxt   = timer;
        pop         = 1'b0;
        reg_we      = 1'b0;
        tx_we_nxt   = 1'b0;
        tx_data_nxt = tx_fifo_data_in;
        debug_nxt   = Debug_cmd;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (can_pop) begin
                    pop = 1'b1;
                    if (rx_fifo_data_out == OP_WR || rx_fifo_data_out == OP_RD) begin
                        is_wr_nxt = (rx_fifo_data_out == OP_WR);
                        state_nxt = GET_ADDR;
                    end else begin
                        reply_nxt = RPL_BAD;
                        state_nxt = SEND;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                if (can_pop) begin
                    pop       = 1'b1;
                    timer_nxt = '0;
                    if (state == GET_ADDR) begin
                        addr_nxt  = rx_fifo_data_out;
                        state_nxt = is_wr ? GET_DATA : EXEC;
                    end else begin
                        data_nxt  = rx_fifo_data_out;
                        state_nxt = EXEC;
                    end
                end else if (!rx_fifo_read_en) begin
                    timer_nxt = timer + 1'b1;
                    if (timer_nxt == TIMEOUT_TC) begin
                        timer_nxt = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            EXEC: begin
                state_nxt = SEND;
                if (addr[7:4] != 4'h0) begin
                    reply_nxt = RPL_ERR;
                end else if (is_wr) begin
                    reg_we    = 1'b1;
                    reply_nxt = RPL_OK;
                end else begin
                    reply_nxt = regs[addr[3:0]];
                end
            end
            SEND: begin
                if (!tx_fifo_full) begin
                    tx_we_nxt   = 1'b1;
                    tx_data_nxt = reply;
                    debug_nxt   = ~Debug_cmd;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            is_wr            <= 1'b0;
            addr             <= '0;
            data             <= '0;
            reply            <= '0;
            timer            <= '0;
            regs             <= '0;
            rx_fifo_read_en  <= 1'b0;
            tx_fifo_write_en <= 1'b0;
            tx_fifo_data_in  <= '0;
            write_strobe     <= 1'b0;
            write_addr       <= '0;
            Debug_cmd        <= 1'b0;
        end else begin
            state            <= state_nxt;
            is_wr            <= is_wr_nxt;
            addr             <= addr_nxt;
            data             <= data_nxt;
            reply            <= reply_nxt;
            timer            <= timer_nxt;
            rx_fifo_read_en  <= pop;
            tx_fifo_write_en <= tx_we_nxt;
            tx_fifo_data_in  <= tx_data_nxt;
            write_strobe     <= reg_we;
            Debug_cmd        <= debug_nxt;
            if (reg_we) begin
                regs[addr[3:0]] <= data;
                write_addr      <= addr[3:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: a command table plus hand-written
// timeout, TX back-pressure and mid-command reset sequences.
`timescale 1ns/1ps
module tb_uart_cmd_responder;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         rx_fifo_empty = 1'b1;
    logic [7:0]   rx_fifo_data_out = 8'h00;
    logic         rx_fifo_read_en;
    logic         tx_fifo_full = 1'b0;
    logic [7:0]   tx_fifo_data_in;
    logic         tx_fifo_write_en;
    logic [127:0] regs_flat;
    logic         write_strobe;
    logic [3:0]   write_addr;
    logic         Debug_cmd;

    uart_cmd_responder #(.TIMEOUT_CYCLES(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .rx_fifo_empty    (rx_fifo_empty),
        .rx_fifo_data_out (rx_fifo_data_out),
        .rx_fifo_read_en  (rx_fifo_read_en),
        .tx_fifo_full     (tx_fifo_full),
        .tx_fifo_data_in  (tx_fifo_data_in),
        .tx_fifo_write_en (tx_fifo_write_en),
        .regs_flat        (regs_flat),
        .write_strobe     (write_strobe),
        .write_addr       (write_addr),
        .Debug_cmd        (Debug_cmd)
    );

    always #5 clock = ~clock;

    // RX FIFO model (written by the stimulus), drained and observed at negedge.
    logic [7:0] rxq[$];
    logic [7:0] txlog[$];
    int rd_ptr = 0;
    int cyc = 0, pops = 0, strobes = 0, back2back = 0;
    int last_pop_cyc = 0, last_wr_cyc = 0;
    logic [3:0] last_waddr = 4'h0;
    logic prev_re = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (rx_fifo_read_en) begin
            pops++;
            last_pop_cyc = cyc;
            if (prev_re) back2back++;
            if (rd_ptr < rxq.size()) rd_ptr++;
        end
        prev_re = rx_fifo_read_en;
        if (tx_fifo_write_en) begin
            txlog.push_back(tx_fifo_data_in);
            last_wr_cyc = cyc;
        end
        if (write_strobe) begin
            strobes++;
            last_waddr = write_addr;
        end
        rx_fifo_empty    = (rd_ptr >= rxq.size());
        rx_fifo_data_out = (rd_ptr < rxq.size()) ? rxq[rd_ptr] : 8'h00;
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (txlog.size() >= n) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_pops(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pops >= n) begin ok = 1'b1; break; end
            step();
        end
    endtask

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        logic [7:0] tx;
        bit         ws;
        logic [3:0] wa;
    } vec_t;

    function automatic vec_t mkv(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                 logic [7:0] tx, bit ws, logic [3:0] wa);
        vec_t v;
        v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.tx = tx; v.ws = ws; v.wa = wa;
        return v;
    endfunction

    vec_t       vecs[12];
    logic [127:0] exp_regs = '0;
    logic       exp_dbg = 1'b0;

    initial begin
        bit ok;
        int t0, s0, p0, p1;

        vecs[0]  = mkv(3, 8'h57, 8'h03, 8'hA5, 8'h4B, 1'b1, 4'h3);
        vecs[1]  = mkv(2, 8'h52, 8'h03, 8'h00, 8'hA5, 1'b0, 4'h0);
        vecs[2]  = mkv(1, 8'h41, 8'h00, 8'h00, 8'h3F, 1'b0, 4'h0);
        vecs[3]  = mkv(3, 8'h57, 8'h10, 8'h11, 8'h45, 1'b0, 4'h0);
        vecs[4]  = mkv(3, 8'h57, 8'h0F, 8'h5A, 8'h4B, 1'b1, 4'hF);
        vecs[5]  = mkv(2, 8'h52, 8'h0F, 8'h00, 8'h5A, 1'b0, 4'h0);
        vecs[6]  = mkv(2, 8'h52, 8'h20, 8'h00, 8'h45, 1'b0, 4'h0);
        vecs[7]  = mkv(2, 8'h52, 8'h00, 8'h00, 8'h00, 1'b0, 4'h0);
        vecs[8]  = mkv(3, 8'h57, 8'h00, 8'hFF, 8'h4B, 1'b1, 4'h0);
        vecs[9]  = mkv(2, 8'h52, 8'h00, 8'h00, 8'hFF, 1'b0, 4'h0);
        vecs[10] = mkv(1, 8'h00, 8'h00, 8'h00, 8'h3F, 1'b0, 4'h0);
        vecs[11] = mkv(2, 8'h52, 8'h03, 8'h00, 8'hA5, 1'b0, 4'h0);

        // Reset state
        repeat (3) step();
        check("rst_regs", regs_flat, '0);
        check("rst_rd_en", rx_fifo_read_en, 1'b0);
        check("rst_wr_en", tx_fifo_write_en, 1'b0);
        check("rst_tx_data", tx_fifo_data_in, 8'h00);
        check("rst_strobe", write_strobe, 1'b0);
        check("rst_waddr", write_addr, 4'h0);
        check("rst_debug", Debug_cmd, 1'b0);
        reset = 1'b0;
        repeat (2) step();

        // Timeout: 'W' then 16 idle cycles aborts; following 'R' 0x00 reads reg[0]=0
        t0 = txlog.size(); s0 = strobes; p0 = pops;
        rxq.push_back(8'h57);
        wait_pops(p0 + 1, ok);
        check("to_first_pop", ok, 1'b1);
        repeat (16) step();
        rxq.push_back(8'h52);
        rxq.push_back(8'h00);
        wait_tx(t0 + 1, ok);
        check("to_reply_seen", ok, 1'b1);
        if (ok) check("to_reply", txlog[t0], 8'h00);
        repeat (20) step();
        check("to_single_reply", txlog.size(), t0 + 1);
        check("to_no_write", strobes, s0);
        exp_dbg = ~exp_dbg;
        check("to_debug", Debug_cmd, exp_dbg);

        // Command table
        foreach (vecs[i]) begin
            t0 = txlog.size(); s0 = strobes;
            rxq.push_back(vecs[i].b0);
            if (vecs[i].n > 1) rxq.push_back(vecs[i].b1);
            if (vecs[i].n > 2) rxq.push_back(vecs[i].b2);
            wait_tx(t0 + 1, ok);
            check($sformatf("v%0d_done", i), ok, 1'b1);
            if (ok) check($sformatf("v%0d_tx", i), txlog[t0], vecs[i].tx);
            repeat (3) step();
            check($sformatf("v%0d_tx_count", i), txlog.size(), t0 + 1);
            check($sformatf("v%0d_strobes", i), strobes - s0, vecs[i].ws ? 1 : 0);
            if (vecs[i].ws) begin
                check($sformatf("v%0d_waddr", i), last_waddr, vecs[i].wa);
                exp_regs[vecs[i].wa*8 +: 8] = vecs[i].b2;
            end
            check($sformatf("v%0d_regs", i), regs_flat, exp_regs);
            exp_dbg = ~exp_dbg;
            check($sformatf("v%0d_debug", i), Debug_cmd, exp_dbg);
            if (vecs[i].n > 1)
                check($sformatf("v%0d_latency", i), last_wr_cyc - last_pop_cyc, 2);
        end

        // TX back-pressure: no write and no pops while full, write right after it falls
        tx_fifo_full = 1'b1;
        t0 = txlog.size(); p0 = pops;
        rxq.push_back(8'h52);
        rxq.push_back(8'h03);
        rxq.push_back(8'h41);
        wait_pops(p0 + 2, ok);
        check("bp_pops", ok, 1'b1);
        p1 = pops;
        repeat (10) step();
        check("bp_no_write", txlog.size(), t0);
        check("bp_no_pop", pops, p1);
        @(posedge clock);
        #1 tx_fifo_full = 1'b0;
        step();
        check("bp_not_early", txlog.size(), t0);
        step();
        check("bp_write_now", txlog.size(), t0 + 1);
        if (txlog.size() > t0) check("bp_data", txlog[t0], 8'hA5);
        wait_tx(t0 + 2, ok);
        check("bp_next_done", ok, 1'b1);
        if (ok) check("bp_next_data", txlog[t0 + 1], 8'h3F);
        repeat (3) step();
        check("bp_tx_count", txlog.size(), t0 + 2);

        // Reset between address and data of a write
        t0 = txlog.size(); s0 = strobes; p0 = pops;
        rxq.push_back(8'h57);
        rxq.push_back(8'h05);
        wait_pops(p0 + 2, ok);
        check("rm_pops", ok, 1'b1);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check("rm_regs", regs_flat, '0);
        check("rm_debug", Debug_cmd, 1'b0);
        repeat (20) step();
        check("rm_no_tx", txlog.size(), t0);
        check("rm_no_write", strobes, s0);
        rxq.push_back(8'h52);
        rxq.push_back(8'h05);
        wait_tx(t0 + 1, ok);
        check("rm_read_done", ok, 1'b1);
        if (ok) check("rm_read", txlog[t0], 8'h00);

        check("no_back_to_back_pop", back2back, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

endmodule
